// File: rtl/sakebi_fcs_appender.sv
// Captures one byte-stream frame into a RAM buffer, then replays it followed by
// its 4-byte FCS once the FCS arrives; overflowing, timed-out or colliding frames are dropped.
module sakebi_fcs_appender #(
  parameter int BUF_DEPTH   = 2048,
  parameter int CRC_TIMEOUT = 32
) (
  input  logic        i_axis_ACLK,
  input  logic        i_axis_ARESET,
  input  logic        i_axis_TVALID,
  input  logic [7:0]  i_axis_TDATA,
  input  logic        i_crc_TVALID,
  input  logic [31:0] i_crc_TDATA,
  input  logic        i_axis_TREADY,
  output logic        o_axis_TVALID,
  output logic [7:0]  o_axis_TDATA,
  output logic        o_axis_TLAST,
  output logic        o_drop,
  output logic        o_busy
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int TW = $clog2(CRC_TIMEOUT + 1);
  localparam logic [AW:0]   LEN_FULL = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CRC_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_WAIT_CRC, S_SEND_DATA, S_SEND_FCS, S_SKIP
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;
  logic [1:0]    fcs_idx_q, fcs_idx_d;
  logic [31:0]   fcs_q, fcs_d;
  logic          ovalid_q, ovalid_d;
  logic [7:0]    odata_q, odata_d;
  logic          olast_q, olast_d;
  logic          drop_q, drop_d;
  logic          skip_arm_q, skip_arm_d;
  logic          tv_prev_q;

  logic          we, re, intrude, load;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    mem [BUF_DEPTH];
  logic [7:0]    rdata_q;

  assign intrude = i_axis_TVALID & ~tv_prev_q;
  assign load    = ~ovalid_q | i_axis_TREADY;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ovf_d      = ovf_q;
    tmo_d      = tmo_q;
    tx_cnt_d   = tx_cnt_q;
    fcs_idx_d  = fcs_idx_q;
    fcs_d      = fcs_q;
    ovalid_d   = ovalid_q;
    odata_d    = odata_q;
    olast_d    = olast_q;
    drop_d     = 1'b0;
    skip_arm_d = skip_arm_q & i_axis_TVALID;
    we         = 1'b0;
    waddr      = len_q[AW-1:0];
    re         = 1'b0;
    raddr      = tx_cnt_q[AW-1:0] + AW'(1);

    // A frame starting while another is pending is dropped and skipped until it ends
    if (intrude && (state_q inside {S_WAIT_CRC, S_SEND_DATA, S_SEND_FCS})) begin
      drop_d     = 1'b1;
      skip_arm_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_axis_TVALID) begin
          if (skip_arm_q) begin
            state_d = S_SKIP;
          end else begin
            we      = 1'b1;
            waddr   = '0;
            len_d   = LEN_ONE;
            ovf_d   = 1'b0;
            state_d = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        if (i_axis_TVALID) begin
          if (len_q == LEN_FULL) begin
            ovf_d = 1'b1;
          end else begin
            we    = 1'b1;
            len_d = len_q + LEN_ONE;
          end
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT_CRC;
        end
      end
      S_WAIT_CRC: begin
        if (i_crc_TVALID) begin
          fcs_d = i_crc_TDATA;
          if (ovf_q) begin
            drop_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            re       = 1'b1;
            raddr    = '0;
            tx_cnt_d = '0;
            state_d  = S_SEND_DATA;
          end
        end else if (tmo_q == TMO_LAST) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_SEND_DATA: begin
        if (load) begin
          ovalid_d = 1'b1;
          odata_d  = rdata_q;
          olast_d  = 1'b0;
          re       = 1'b1;
          tx_cnt_d = tx_cnt_q + LEN_ONE;
          if (tx_cnt_q == len_q - LEN_ONE) begin
            fcs_idx_d = '0;
            state_d   = S_SEND_FCS;
          end
        end
      end
      S_SEND_FCS: begin
        if (ovalid_q && olast_q && i_axis_TREADY) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          state_d  = S_IDLE;
        end else if (load && !olast_q) begin
          ovalid_d  = 1'b1;
          odata_d   = fcs_q[{fcs_idx_q, 3'b000} +: 8];
          olast_d   = (fcs_idx_q == 2'd3);
          fcs_idx_d = fcs_idx_q + 2'd1;
        end
      end
      S_SKIP: begin
        if (!i_axis_TVALID) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // skip_arm resets high so a frame already in flight at reset release is skipped
  always_ff @(posedge i_axis_ACLK or posedge i_axis_ARESET) begin
    if (i_axis_ARESET) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= '0;
      tx_cnt_q   <= '0;
      fcs_idx_q  <= '0;
      fcs_q      <= '0;
      ovalid_q   <= 1'b0;
      odata_q    <= '0;
      olast_q    <= 1'b0;
      drop_q     <= 1'b0;
      skip_arm_q <= 1'b1;
      tv_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      tx_cnt_q   <= tx_cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      fcs_q      <= fcs_d;
      ovalid_q   <= ovalid_d;
      odata_q    <= odata_d;
      olast_q    <= olast_d;
      drop_q     <= drop_d;
      skip_arm_q <= skip_arm_d;
      tv_prev_q  <= i_axis_TVALID;
    end
  end

  always_ff @(posedge i_axis_ACLK) begin
    if (we) mem[waddr] <= i_axis_TDATA;
    if (re) rdata_q <= mem[raddr];
  end

  assign o_axis_TVALID = ovalid_q;
  assign o_axis_TDATA  = odata_q;
  assign o_axis_TLAST  = olast_q;
  assign o_drop        = drop_q;
  assign o_busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sakebi_fcs_appender.sv
// Self-checking bench for sakebi_fcs_appender: table of frame scenarios, random frames,
// and hand-written collision/reset sequences checked against a queue-based frame model.
module tb_sakebi_fcs_appender;
  localparam int DEPTH = 64;
  localparam int TMO   = 32;

  logic        clk = 1'b0, rst = 1'b1;
  logic        tv = 1'b0, crc_v = 1'b0, rdy = 1'b1;
  logic [7:0]  td = '0;
  logic [31:0] crc_d = '0;
  logic        o_v, o_l, o_drop, o_busy;
  logic [7:0]  o_d;

  sakebi_fcs_appender #(.BUF_DEPTH(DEPTH), .CRC_TIMEOUT(TMO)) dut (
    .i_axis_ACLK(clk), .i_axis_ARESET(rst),
    .i_axis_TVALID(tv), .i_axis_TDATA(td),
    .i_crc_TVALID(crc_v), .i_crc_TDATA(crc_d),
    .i_axis_TREADY(rdy),
    .o_axis_TVALID(o_v), .o_axis_TDATA(o_d), .o_axis_TLAST(o_l),
    .o_drop(o_drop), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int ready_mode = 0;
  int last_byte_cyc, crc_cyc;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit         last_q[$];
  int first_vo_cyc, first_x_cyc, last_x_cyc, drop_cnt, drop_cyc;
  bit pv, pr, pl;
  logic [7:0] pd;

  typedef struct {
    int          n;
    logic [31:0] crc;
    int          gap;
    bit          give_crc;
    int          mode;
    bit          rnd;
    int          exp_drops;
    int          exp_out;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: collects transfers, drops, and verifies hold-while-stalled
  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        n_cmp++;
        if (!(o_v === 1'b1 && o_d === pd && o_l === pl)) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%b",
                   cyc, o_v, o_d, o_l, pd, pl);
        end
      end
      if (o_v && first_vo_cyc < 0) first_vo_cyc = cyc;
      if (o_v && rdy) begin
        got_q.push_back(o_d);
        last_q.push_back(o_l);
        if (first_x_cyc < 0) first_x_cyc = cyc;
        last_x_cyc = cyc;
      end
      if (o_drop) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
      pv = o_v; pr = rdy; pd = o_d; pl = o_l;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: rdy = 1'b1;
        1: rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    got_q.delete(); last_q.delete(); exp_q.delete();
    first_vo_cyc = -1; first_x_cyc = -1; last_x_cyc = -1;
    drop_cnt = 0; drop_cyc = -1;
  endtask

  task automatic drive_bytes(input int n, input bit rnd, input bit rec);
    for (int i = 0; i < n; i++) begin
      tv = 1'b1;
      td = rnd ? 8'($urandom) : 8'(i);
      if (rec) exp_q.push_back(td);
      last_byte_cyc = cyc;
      tick();
    end
    tv = 1'b0;
  endtask

  // gap counts cycles from the last frame byte to the FCS pulse
  task automatic pulse_crc(input int gap, input logic [31:0] crc, input bit rec);
    repeat (gap - 1) tick();
    crc_v = 1'b1;
    crc_d = crc;
    crc_cyc = cyc;
    tick();
    crc_v = 1'b0;
    if (rec) begin
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[23:16]);
      exp_q.push_back(crc[31:24]);
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 600; i++) begin
      if (!o_busy && !o_v) break;
      tick();
    end
    check({name, " idle_reached"}, (i < 600), 1);
    repeat (3) tick();
  endtask

  task automatic check_out(input string name, input int exp_drops, input bit nobubble);
    int bad, nl, li;
    check({name, " drops"}, drop_cnt, exp_drops);
    check({name, " nbytes"}, got_q.size(), exp_q.size());
    if (exp_q.size() > 0) begin
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0)
        $display("  first differing byte %0d: got %h, expected %h", bad, got_q[bad], exp_q[bad]);
      check({name, " first_bad_byte"}, bad, -1);
      check({name, " latency"}, first_vo_cyc - crc_cyc, 2);
      nl = 0; li = -1;
      for (int i = 0; i < last_q.size(); i++) if (last_q[i]) begin nl++; li = i; end
      check({name, " tlast_count"}, nl, 1);
      check({name, " tlast_index"}, li, exp_q.size() - 1);
      if (nobubble) check({name, " span"}, last_x_cyc - first_x_cyc + 1, exp_q.size());
    end
    check({name, " busy_after"}, o_busy, 0);
  endtask

  initial begin
    bit acc;
    int n, gap;

    tbl[0] = '{60, 32'hDEADBEEF, 6, 1'b1, 0, 1'b0, 0, 64};
    tbl[1] = '{60, 32'hDEADBEEF, 6, 1'b1, 1, 1'b0, 0, 64};
    tbl[2] = '{10, 32'h0,        6, 1'b0, 0, 1'b0, 1, 0};
    tbl[3] = '{70, 32'h12345678, 4, 1'b1, 0, 1'b1, 1, 0};
    tbl[4] = '{64, 32'hCAFEF00D, 2, 1'b1, 2, 1'b1, 0, 68};
    tbl[5] = '{65, 32'h0BADF00D, 3, 1'b1, 0, 1'b1, 1, 0};
    tbl[6] = '{1,  32'hA5A55A5A, TMO + 1, 1'b1, 2, 1'b1, 0, 5};
    tbl[7] = '{5,  32'h11223344, TMO + 2, 1'b1, 0, 1'b1, 1, 0};

    rst = 1'b1;
    repeat (3) tick();
    check("reset o_valid", o_v, 0);
    check("reset o_data", o_d, 0);
    check("reset o_last", o_l, 0);
    check("reset o_drop", o_drop, 0);
    check("reset o_busy", o_busy, 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int t = 0; t < 8; t++) begin
      string nm;
      nm = $sformatf("vec%0d", t);
      clear_mon();
      ready_mode = tbl[t].mode;
      // WAIT_CRC spans TMO cycles beginning two cycles after the last byte
      acc = tbl[t].give_crc && (tbl[t].gap <= TMO + 1);
      drive_bytes(tbl[t].n, tbl[t].rnd, acc && tbl[t].n <= DEPTH);
      if (tbl[t].give_crc) pulse_crc(tbl[t].gap, tbl[t].crc, acc && tbl[t].n <= DEPTH);
      wait_idle(nm);
      check({nm, " out_table"}, got_q.size(), tbl[t].exp_out);
      check_out(nm, tbl[t].exp_drops, tbl[t].mode == 0);
      if (!acc) check({nm, " timeout_cycle"}, drop_cyc - last_byte_cyc, TMO + 2);
    end

    for (int r = 0; r < 10; r++) begin
      clear_mon();
      ready_mode = 2;
      n = $urandom_range(1, 72);
      gap = $urandom_range(2, 20);
      drive_bytes(n, 1'b1, n <= DEPTH);
      pulse_crc(gap, $urandom, n <= DEPTH);
      wait_idle($sformatf("rnd%0d", r));
      check_out($sformatf("rnd%0d n=%0d", r, n), (n <= DEPTH) ? 0 : 1, 1'b0);
    end

    // Second frame arriving during SEND_DATA: dropped once, first frame intact
    clear_mon();
    ready_mode = 0;
    drive_bytes(60, 1'b1, 1'b1);
    pulse_crc(4, $urandom, 1'b1);
    repeat (6) tick();
    drive_bytes(8, 1'b1, 1'b0);
    wait_idle("intrude");
    check_out("intrude", 1, 1'b1);

    // Intruder still running when the first frame finishes: skipped, no second drop
    clear_mon();
    drive_bytes(10, 1'b1, 1'b1);
    pulse_crc(3, $urandom, 1'b1);
    repeat (2) tick();
    drive_bytes(40, 1'b1, 1'b0);
    check("skip busy_during", o_busy, 1);
    wait_idle("intrude_skip");
    check_out("intrude_skip", 1, 1'b1);

    clear_mon();
    drive_bytes(20, 1'b1, 1'b1);
    pulse_crc(5, $urandom, 1'b1);
    wait_idle("after_skip");
    check_out("after_skip", 0, 1'b1);

    // Reset at byte 5 of a 20-byte frame, released while the frame continues
    clear_mon();
    for (int i = 0; i < 5; i++) begin tv = 1'b1; td = 8'(i); tick(); end
    rst = 1'b1;
    tick();
    check("midreset o_busy", o_busy, 0);
    check("midreset o_valid", o_v, 0);
    tick();
    rst = 1'b0;
    for (int i = 5; i < 20; i++) begin td = 8'(i); tick(); end
    tv = 1'b0;
    repeat (TMO + 10) tick();
    check_out("midreset", 0, 1'b0);

    clear_mon();
    drive_bytes(20, 1'b1, 1'b1);
    pulse_crc(6, 32'h89ABCDEF, 1'b1);
    wait_idle("post_reset");
    check_out("post_reset", 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 2000000");
    $fatal(1);
  end

endmodule
